// File: rtl/riot_io_timer.sv
// riot_io_timer: RIOT-style pair of bidirectional I/O ports plus a programmable interval timer
module riot_io_timer #(
   parameter logic [9:0] IOT_BASE = 10'd0,
   parameter int         PW       = 8,
   parameter int         TW       = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          tick_en,
   input  logic          RW,
   input  logic [9:0]    A,
   input  logic          CS1,
   input  logic [7:0]    DI,
   output logic [7:0]    DO,
   output logic          OE,
   output logic [PW-1:0] PAO,
   output logic [PW-1:0] PAOE,
   input  logic [PW-1:0] PAI,
   output logic [PW-1:0] PBO,
   output logic [PW-1:0] PBOE,
   input  logic [PW-1:0] PBI,
   output logic          irq_n
);
   typedef enum logic {S_COUNT, S_EXPIRED} state_t;
   state_t        r_state, w_state_nx;
   logic [PW-1:0] r_pao, r_paoe, r_pbo, r_pboe, w_pa_rd, w_pb_rd;
   logic [TW-1:0] r_timer;
   logic [9:0]    r_presc, w_div_m1;
   logic [1:0]    r_div;
   logic [7:0]    r_do, w_rdata;
   logic          r_oe, r_flag, r_irq_en;
   logic          w_sel, w_rd, w_wr, w_tmr_wr, w_tmr_rd, w_dec, w_uf, w_unused;

   assign w_sel    = !CS1 && (A[9:6] == IOT_BASE[9:6]);
   assign w_rd     = w_sel && RW;
   assign w_wr     = w_sel && !RW;
   assign w_tmr_wr = w_wr && A[2];
   assign w_tmr_rd = w_rd && A[2] && !A[0];
   // Once expired the timer decrements on every tick regardless of the programmed divider
   assign w_div_m1 = (r_state == S_EXPIRED) ? 10'd0 :
                     (r_div == 2'd0) ? 10'd0 : (r_div == 2'd1) ? 10'd7 :
                     (r_div == 2'd2) ? 10'd63 : 10'd1023;
   assign w_dec    = tick_en && (r_presc == w_div_m1);
   assign w_uf     = w_dec && (r_timer == '0);
   assign w_pa_rd  = (r_paoe & r_pao) | (~r_paoe & PAI);
   assign w_pb_rd  = (r_pboe & r_pbo) | (~r_pboe & PBI);
   assign w_rdata  = A[2] ? (A[0] ? {r_flag, 7'b0} : r_timer[7:0]) :
                     A[1] ? (A[0] ? 8'(r_pboe) : 8'(w_pb_rd)) :
                            (A[0] ? 8'(r_paoe) : 8'(w_pa_rd));
   assign w_unused = ^A[5:4];

   assign DO    = r_do;
   assign OE    = r_oe;
   assign PAO   = r_pao;
   assign PAOE  = r_paoe;
   assign PBO   = r_pbo;
   assign PBOE  = r_pboe;
   assign irq_n = !(r_flag && r_irq_en);

   // Timer mode register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_COUNT;
      else          r_state <= w_state_nx;
   end

   // Mode transitions: a timer write always restarts counting and beats a simultaneous underflow
   always_comb begin
      w_state_nx = r_state;
      w_state_nx = w_tmr_wr ? S_COUNT : w_uf ? S_EXPIRED : r_state;
   end

   // Port data and direction registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pao  <= '0;
         r_paoe <= '0;
         r_pbo  <= '0;
         r_pboe <= '0;
      end else if (w_wr && !A[2]) begin
         if (A[1:0] == 2'd0) r_pao  <= DI[PW-1:0];
         if (A[1:0] == 2'd1) r_paoe <= DI[PW-1:0];
         if (A[1:0] == 2'd2) r_pbo  <= DI[PW-1:0];
         if (A[1:0] == 2'd3) r_pboe <= DI[PW-1:0];
      end
   end

   // Registered read data with a one-cycle valid strobe per read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_oe <= 1'b0;
         r_do <= 8'h00;
      end else begin
         r_oe <= w_rd;
         if (w_rd) r_do <= w_rdata;
      end
   end

   // Timer, prescaler, interrupt flag and enable; an underflow flag beats a clearing read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timer  <= '0;
         r_presc  <= '0;
         r_div    <= 2'd0;
         r_flag   <= 1'b0;
         r_irq_en <= 1'b0;
      end else if (w_tmr_wr) begin
         r_timer  <= TW'(DI);
         r_presc  <= '0;
         r_div    <= A[1:0];
         r_flag   <= 1'b0;
         r_irq_en <= A[3];
      end else begin
         if (tick_en) r_presc <= w_dec ? '0 : r_presc + 10'd1;
         if (w_dec) r_timer <= r_timer - TW'(1);
         if (w_tmr_rd) r_irq_en <= A[3];
         if (w_uf) r_flag <= 1'b1;
         else if (w_tmr_rd) r_flag <= 1'b0;
      end
   end
endmodule

// File: tb/tb_riot_io_timer.sv
// tb_riot_io_timer: directed self-checking bench for riot_io_timer
module tb_riot_io_timer;
   logic       clk = 1'b0;
   logic       reset_n, tick_en, RW, CS1;
   logic [9:0] A;
   logic [7:0] DI, DO, PAO, PAOE, PAI, PBO, PBOE, PBI;
   logic       OE, irq_n;
   logic [7:0] r_d;
   logic       r_o;
   int         n_chk = 0;
   int         n_err = 0;

   riot_io_timer dut (
      .clk(clk), .reset_n(reset_n), .tick_en(tick_en), .RW(RW), .A(A), .CS1(CS1),
      .DI(DI), .DO(DO), .OE(OE), .PAO(PAO), .PAOE(PAOE), .PAI(PAI),
      .PBO(PBO), .PBOE(PBOE), .PBI(PBI), .irq_n(irq_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [9:0] a, input logic [7:0] d);
      CS1 = 1'b0;
      RW  = 1'b0;
      A   = a;
      DI  = d;
      step();
      CS1 = 1'b1;
      RW  = 1'b1;
   endtask

   task automatic rd(input logic [9:0] a, output logic [7:0] d, output logic o);
      CS1 = 1'b0;
      RW  = 1'b1;
      A   = a;
      step();
      CS1 = 1'b1;
      d   = DO;
      o   = OE;
   endtask

   initial begin
      reset_n = 1'b0;
      tick_en = 1'b0;
      RW = 1'b1;
      CS1 = 1'b1;
      A = '0;
      DI = '0;
      PAI = 8'h3C;
      PBI = 8'hC3;
      step();
      step();
      chk("rst_oe", OE, 0);
      chk("rst_do", DO, 0);
      chk("rst_irq", irq_n, 1);
      chk("rst_pao", PAO, 0);
      chk("rst_pboe", PBOE, 0);
      reset_n = 1'b1;
      // I/O ports
      wr(10'h001, 8'h0F);
      wr(10'h000, 8'hA5);
      wr(10'h003, 8'hF0);
      wr(10'h002, 8'h5A);
      chk("pao", PAO, 8'hA5);
      chk("paoe", PAOE, 8'h0F);
      rd(10'h000, r_d, r_o);
      chk("pa_rd", r_d, 8'h35);
      chk("pa_oe", r_o, 1);
      step();
      chk("oe_drop", OE, 0);
      rd(10'h002, r_d, r_o);
      chk("pb_rd", r_d, 8'h53);
      rd(10'h003, r_d, r_o);
      chk("ddrb_rd", r_d, 8'hF0);
      // Unselected accesses
      wr(10'h040, 8'hFF);
      chk("unsel_base", PAO, 8'hA5);
      CS1 = 1'b1; RW = 1'b0; A = 10'h000; DI = 8'h00;
      step();
      RW = 1'b1;
      chk("unsel_cs", PAO, 8'hA5);
      rd(10'h041, r_d, r_o);
      chk("unsel_oe", r_o, 0);
      // Divider 8, load 2, irq enabled: underflow on the 24th tick
      tick_en = 1'b1;
      wr(10'h00D, 8'h02);
      repeat (23) step();
      chk("d8_pre", irq_n, 1);
      step();
      chk("d8_irq", irq_n, 0);
      rd(10'h00C, r_d, r_o);
      chk("exp_ff", r_d, 8'hFF);
      chk("exp_clr", irq_n, 1);
      rd(10'h004, r_d, r_o);
      chk("exp_fe", r_d, 8'hFE);
      rd(10'h005, r_d, r_o);
      chk("exp_stat", r_d, 8'h00);
      rd(10'h004, r_d, r_o);
      chk("exp_fc", r_d, 8'hFC);
      // Timer read on the underflow cycle: read sees old value, flag still sets
      wr(10'h00C, 8'h00);
      rd(10'h00C, r_d, r_o);
      chk("uf_rd_val", r_d, 8'h00);
      chk("uf_rd_irq", irq_n, 0);
      rd(10'h005, r_d, r_o);
      chk("uf_rd_stat", r_d, 8'h80);
      chk("stat_keep", irq_n, 0);
      rd(10'h004, r_d, r_o);
      chk("uf_rd_fe", r_d, 8'hFE);
      chk("a3_off_irq", irq_n, 1);
      rd(10'h005, r_d, r_o);
      chk("a3_off_stat", r_d, 8'h00);
      // Timer write on the underflow cycle wins
      wr(10'h004, 8'h00);
      wr(10'h00E, 8'h10);
      chk("wwin_irq", irq_n, 1);
      rd(10'h005, r_d, r_o);
      chk("wwin_stat", r_d, 8'h00);
      rd(10'h00C, r_d, r_o);
      chk("wwin_tmr", r_d, 8'h10);
      // Divider 64 with tick_en at half rate: underflow after 256 clocks
      tick_en = 1'b0;
      wr(10'h00E, 8'h01);
      for (int k = 1; k <= 255; k++) begin
         tick_en = (k % 2 == 0);
         step();
      end
      chk("d64_pre", irq_n, 1);
      tick_en = 1'b1;
      step();
      chk("d64_irq", irq_n, 0);
      wr(10'h001, 8'hFF);
      chk("ddr_keep_irq", irq_n, 0);
      // Asynchronous reset mid-read with irq pending
      rd(10'h001, r_d, r_o);
      chk("mid_oe", r_o, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_irq", irq_n, 1);
      chk("ar_oe", OE, 0);
      chk("ar_do", DO, 0);
      chk("ar_pao", PAO, 0);
      chk("ar_paoe", PAOE, 0);
      chk("ar_pbo", PBO, 0);
      step();
      tick_en = 1'b0;
      reset_n = 1'b1;
      rd(10'h004, r_d, r_o);
      chk("post_tmr", r_d, 8'h00);
      rd(10'h005, r_d, r_o);
      chk("post_stat", r_d, 8'h00);
      rd(10'h001, r_d, r_o);
      chk("post_ddra", r_d, 8'h00);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/riot_io_timer.md
RIOT_IO_TIMER -- requirements
Module: riot_io_timer

Interface
REQ-001 SHALL have parameter IOT_BASE, default 0, 10-bit base; block selected when A[9:6]==IOT_BASE[9:6].
REQ-002 SHALL have parameter PW, default 8, range 1..8; width of each I/O port, with unused data bits above PW reading 0.
REQ-003 SHALL have parameter TW, default 8, range 8..16; timer width, with upper bits loaded from 0 and read as the low byte only.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 tick_en  in  1  timer time-base enable; prescaler advances only on cycles where it is 1.
REQ-007 RW  in  1  1=read, 0=write.
REQ-008 A  in  10  address.
REQ-009 CS1  in  1  active-low chip select.
REQ-010 DI  in  8  write data.
REQ-011 DO  out  8  registered read data.
REQ-012 OE  out  1  DO valid, registered.
REQ-013 PAO / PAOE / PAI  out/out/in  PW each  port A data, direction (1=output), and pin input.
REQ-014 PBO / PBOE / PBI  out/out/in  PW each  port B data, direction (1=output), and pin input.
REQ-015 irq_n  out  1  active-low interrupt = !(flag & irq_en).

Function
REQ-016 Select SHALL be sel = !CS1 && A[9:6]==IOT_BASE[9:6]; no state change when sel=0.
REQ-017 Register map on A[2]=0 SHALL be: A[1:0] 00 PA data, 01 DDRA, 10 PB data, 11 DDRB; read and write as addressed.
REQ-018 Port reads SHALL return per bit OE? out:in (PAOE[i]?PAO[i]:PAI[i]; same for B).
REQ-019 Write with A[2]=1 SHALL: load timer with DI, set divider from A[1:0] (00=1, 01=8, 10=64, 11=1024), set irq_en=A[3], clear flag, and reset prescaler to 0.
REQ-020 Read with A[2]=1, A[0]=0 SHALL: return the timer low byte, set irq_en=A[3], and clear flag.
REQ-021 Read with A[2]=1, A[0]=1 SHALL return {flag,7'b0} and leave flag unchanged.
REQ-022 Read latency SHALL be 1 cycle: DO/OE valid the cycle after a selected read; OE=1 for exactly one cycle per read cycle; OE=0 otherwise.
REQ-023 Prescaler SHALL count tick_en pulses; on reaching divider-1 it wraps to 0 and produces one timer decrement.
REQ-024 Timer states SHALL be COUNT (programmed divider) and EXPIRED (divider forced to 1).
REQ-025 On decrement from 0 the timer SHALL wrap to all-ones, set flag, and enter EXPIRED; it keeps decrementing every tick_en, wrapping freely.
REQ-026 Only a timer write (REQ-019) SHALL return the block to COUNT; reads do not.
REQ-027 Timer write in the same cycle as an underflow: write wins (new value, flag=0, COUNT).
REQ-028 Status/timer read in the same cycle as an underflow: flag ends 1; the read returns the pre-update value.
REQ-029 irq_n SHALL be combinational from registered flag and irq_en, glitch-free relative to clk.
REQ-030 Writes to non-timer registers SHALL not disturb the timer or prescaler.

Reset
REQ-031 reset_n=0 SHALL immediately clear PAO, PAOE, PBO, PBOE, OE, DO, timer, prescaler, flag, and irq_en; state COUNT, divider=1; irq_n=1.
REQ-032 Reset asserted mid-count or mid-read SHALL abort; after release the first action requires a new timer write.

Verification
REQ-033 DDRA=0x0F, PA=0xA5, PAI=0x3C; read PA -> DO=0x35, OE=1 one cycle later.
REQ-034 tick_en=1 constantly; write timer 0x02 with A[1:0]=01, A[3]=1 -> flag sets and irq_n=0 after 24 ticks; timer reads 0xFF then decrements by 1 per tick.
REQ-035 Expired timer; read timer with A[3]=0 -> irq_n=1 and status reads 0x00; timer keeps decrementing at divider 1.
REQ-036 Write timer 0x10 on the exact cycle of underflow -> timer=0x10, flag=0, divider per A[1:0].
REQ-037 tick_en toggling 1/0; divider 64, load 0x01 -> underflow after 128 ticks, i.e. 256 clk.
REQ-038 Assert reset_n mid-count with irq pending -> irq_n=1, all ports 0, and OE=0 in the same cycle, without waiting for a clk edge.
